// File: rtl/mips32_issue_interlock.sv
`default_nettype none
// ============================================================================
// Module   : mips32_issue_interlock
// Purpose  : ID-stage issue gate for the 5-stage MIPS32 pipe (scoreboard
//            interlock, branch squash, HLT drain, issue/stall statistics).
// Revision : 1.0
// ============================================================================
module mips32_issue_interlock #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             branch_taken,
    output logic             issue,
    output logic             stall,
    output logic             flush,
    output logic             halted,
    output logic [DEPTH-1:0] inflight,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [5:0] w_opcode;
    logic [4:0] w_rs, w_rt, w_rd, w_dest;
    logic       w_use_rs, w_use_rt, w_has_dest, w_is_hlt, w_hazard;
    logic       w_unused_bits;

    assign w_opcode      = id_instr[31:26];
    assign w_rs          = id_instr[25:21];
    assign w_rt          = id_instr[20:16];
    assign w_rd          = id_instr[15:11];
    assign w_unused_bits = ^id_instr[10:0];

    always_comb begin
        w_use_rs   = 1'b0;
        w_use_rt   = 1'b0;
        w_has_dest = 1'b0;
        w_is_hlt   = 1'b0;
        w_dest     = w_rd;
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT, c_OP_MUL: begin
                w_use_rs   = 1'b1;
                w_use_rt   = 1'b1;
                w_has_dest = 1'b1;
            end
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI, c_OP_LW: begin
                w_use_rs   = 1'b1;
                w_has_dest = 1'b1;
                w_dest     = w_rt;
            end
            c_OP_SW: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            c_OP_BNEQZ, c_OP_BEQZ: w_use_rs = 1'b1;
            c_OP_HLT:              w_is_hlt = 1'b1;
            default: ;
        endcase
        // R0 is hard-wired, so it is never tracked as a producer
        if (w_dest == 5'd0) w_has_dest = 1'b0;
    end

    logic [DEPTH-1:0] valid_q, valid_d, hasd_q, hasd_d, w_hit;
    logic [4:0]       dest_q [DEPTH];
    logic [4:0]       dest_d [DEPTH];
    logic             halt_pending_q, halt_pending_d, halted_q, halted_d;
    logic [CNT_W-1:0] issue_count_q, issue_count_d, stall_count_q, stall_count_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = valid_q[gi] & hasd_q[gi] &
                ((w_use_rs & (w_rs != 5'd0) & (dest_q[gi] == w_rs)) |
                 (w_use_rt & (w_rt != 5'd0) & (dest_q[gi] == w_rt)));
        end
    endgenerate

    assign w_hazard    = |w_hit;
    assign issue       = id_valid & ~w_hazard & ~branch_taken & ~halt_pending_q & ~halted_q;
    assign stall       = id_valid & ~issue & ~branch_taken;
    assign flush       = id_valid & branch_taken;
    assign halted      = halted_q;
    assign inflight    = valid_q;
    assign issue_count = issue_count_q;
    assign stall_count = stall_count_q;

    always_comb begin
        valid_d[0] = issue;
        hasd_d[0]  = issue & w_has_dest;
        dest_d[0]  = w_dest;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            hasd_d[i]  = hasd_q[i-1];
            dest_d[i]  = dest_q[i-1];
        end

        halt_pending_d = halt_pending_q;
        halted_d       = halted_q;
        if (issue && w_is_hlt) begin
            halt_pending_d = 1'b1;
        end else if (halt_pending_q && (valid_d == '0)) begin
            // drain completes on the edge that shifts the last entry out
            halt_pending_d = 1'b0;
            halted_d       = 1'b1;
        end

        issue_count_d = issue_count_q;
        if (issue && (issue_count_q != c_CNT_MAX)) issue_count_d = issue_count_q + c_CNT_ONE;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != c_CNT_MAX)) stall_count_d = stall_count_q + c_CNT_ONE;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            hasd_q         <= '0;
            for (int i = 0; i < DEPTH; i++) dest_q[i] <= '0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            issue_count_q  <= '0;
            stall_count_q  <= '0;
        end else begin
            valid_q        <= valid_d;
            hasd_q         <= hasd_d;
            for (int i = 0; i < DEPTH; i++) dest_q[i] <= dest_d[i];
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
            issue_count_q  <= issue_count_d;
            stall_count_q  <= stall_count_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips32_issue_interlock.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_issue_interlock
// Purpose  : Scoreboard bench for mips32_issue_interlock with an issue-history
//            reference model; directed scenarios plus randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_mips32_issue_interlock;
    localparam int DEPTH   = 3;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic             clk1 = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [31:0]      id_instr = '0;
    logic             branch_taken = 1'b0;
    logic             issue, stall, flush, halted;
    logic [DEPTH-1:0] inflight;
    logic [CNT_W-1:0] issue_count, stall_count;

    mips32_issue_interlock #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .branch_taken(branch_taken), .issue(issue), .stall(stall), .flush(flush),
        .halted(halted), .inflight(inflight), .issue_count(issue_count),
        .stall_count(stall_count)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic             issue, stall, flush, halted;
        logic [DEPTH-1:0] infl;
        int               ic, sc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: one entry per past clock, newest first: -2 no issue, -1 issued without dest, else dest reg
    int hist_dest[$];
    int hlt_cyc = -1;
    int cyc     = 0;
    int m_ic    = 0;
    int m_sc    = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] mk(int op, int rs, int rt, int rd);
        logic [5:0] o = op[5:0];
        logic [4:0] a = rs[4:0];
        logic [4:0] b = rt[4:0];
        logic [4:0] c = rd[4:0];
        return {o, a, b, c, 11'h0};
    endfunction

    function automatic void decode(input logic [31:0] ins, output int s1, output int s2,
                                   output int d, output bit hlt);
        int op = int'(ins[31:26]);
        int rs = int'(ins[25:21]);
        int rt = int'(ins[20:16]);
        int rd = int'(ins[15:11]);
        s1 = -1; s2 = -1; d = -1; hlt = 0;
        if (op <= 5) begin s1 = rs; s2 = rt; d = rd; end
        else if (op == 8 || op == 10 || op == 11 || op == 12) begin s1 = rs; d = rt; end
        else if (op == 9) begin s1 = rs; s2 = rt; end
        else if (op == 13 || op == 14) s1 = rs;
        else if (op == 63) hlt = 1;
        if (d == 0) d = -1;
    endfunction

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model
    task automatic step(input bit v, input logic [31:0] ins, input bit bt, input bit rst);
        int s1, s2, d;
        bit hlt, haz, hltd, hp;
        exp_t e;
        @(posedge clk1); #1;
        rst_n = rst; id_valid = v; id_instr = ins; branch_taken = bt;
        if (!rst) begin
            hist_dest.delete(); hlt_cyc = -1; cyc = 0; m_ic = 0; m_sc = 0;
        end
        decode(ins, s1, s2, d, hlt);
        haz = 0;
        for (int i = 0; i < hist_dest.size(); i++) begin
            if (s1 > 0 && hist_dest[i] == s1) haz = 1;
            if (s2 > 0 && hist_dest[i] == s2) haz = 1;
        end
        hltd = (hlt_cyc >= 0) && (cyc >= hlt_cyc + DEPTH + 1);
        hp   = (hlt_cyc >= 0) && !hltd;
        e.issue  = v && !haz && !bt && !hp && !hltd;
        e.stall  = v && !e.issue && !bt;
        e.flush  = v && bt;
        e.halted = hltd;
        for (int i = 0; i < DEPTH; i++)
            e.infl[i] = (i < hist_dest.size()) && (hist_dest[i] != -2);
        e.ic = m_ic;
        e.sc = m_sc;
        sb.push_back(e);
        if (rst) begin
            hist_dest.push_front(e.issue ? d : -2);
            if (hist_dest.size() > DEPTH) void'(hist_dest.pop_back());
            if (e.issue && m_ic < CNT_MAX) m_ic++;
            if (e.stall && m_sc < CNT_MAX) m_sc++;
            if (e.issue && hlt) hlt_cyc = cyc;
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("issue",       issue,       e.issue);
                chk("stall",       stall,       e.stall);
                chk("flush",       flush,       e.flush);
                chk("halted",      halted,      e.halted);
                chk("inflight",    inflight,    e.infl);
                chk("issue_count", issue_count, e.ic);
                chk("stall_count", stall_count, e.sc);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] add_r4_r1_r2;
        int ops[16] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 20, 33, 0};
        add_r4_r1_r2 = mk(0, 1, 2, 4);

        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        idle(1);

        // independent back-to-back issues
        step(1, mk(10, 0, 1, 0), 0, 1);
        step(1, mk(10, 0, 2, 0), 0, 1);
        idle(4);

        // RAW dependency: three stall cycles, then issue
        step(1, mk(10, 0, 1, 0), 0, 1);
        repeat (4) step(1, add_r4_r1_r2, 0, 1);
        idle(4);

        // R0 as destination and source never interlocks
        step(1, mk(10, 0, 0, 0), 0, 1);
        step(1, mk(0, 0, 2, 4), 0, 1);
        idle(4);

        // taken branch squashes a stalled consumer
        step(1, mk(10, 0, 1, 0), 0, 1);
        step(1, add_r4_r1_r2, 0, 1);
        step(1, add_r4_r1_r2, 1, 1);
        repeat (3) step(1, add_r4_r1_r2, 0, 1);
        step(0, '0, 1, 1);
        idle(4);

        // asynchronous reset in the middle of a stall
        step(1, mk(10, 0, 5, 0), 0, 1);
        step(1, mk(0, 5, 5, 6), 0, 1);
        step(1, mk(0, 5, 5, 6), 0, 0);
        step(1, mk(0, 5, 5, 6), 0, 0);
        step(1, mk(0, 5, 5, 6), 0, 1);
        idle(4);

        // randomized traffic over a small register window to provoke hazards
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 400; k++) begin
                int op = ops[$urandom_range(0, 15)];
                if ($urandom_range(0, 99) == 0) op = 63;
                step($urandom_range(0, 99) < 85,
                     mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                     $urandom_range(0, 9) == 0, 1);
            end
            step(0, '0, 0, 0);
            step(1, '0, 0, 0);
        end
        idle(1);

        // issue counter saturation
        for (int k = 0; k < 70000; k++) step(1, mk(20, 1, 1, 1), 0, 1);
        @(negedge clk1);
        chk("issue_count_saturated", issue_count, 16'hFFFF);

        // HLT drain with id_valid held high
        step(0, '0, 0, 0);
        idle(1);
        step(1, mk(10, 0, 3, 0), 0, 1);
        step(1, mk(63, 0, 0, 0), 0, 1);
        repeat (8) step(1, mk(0, 3, 3, 4), 0, 1);
        @(negedge clk1);
        chk("halted_sticky", halted, 1);

        repeat (2) @(posedge clk1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
